// File: rtl/mult_div_unit_pkg.sv
// Shared MDop encodings, FSM state codes and default latencies for the HI/LO unit.
// The controller decode imports the same constants.
package md_defs;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MADD  = 3'b100;
  localparam logic [2:0] MD_MSUB  = 3'b101;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // 11x encodings are reserved and never start an operation.
  function automatic logic md_valid(input logic [2:0] op);
    return !(op[2] && op[1]);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational HI/LO result generator: products, accumulates and quotient/remainder.
// Divide-by-zero is flagged so the caller can leave HI/LO untouched.
module md_arith
  import md_defs::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDop,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [31:0] nHI,
  output logic [31:0] nLO,
  output logic        div_by_zero
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [63:0] acc;
  logic [31:0] dvs;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        sovf;

  assign acc   = {HI, LO};
  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'd0, A} * {32'd0, B};

  assign div_by_zero = (B == '0);
  // A non-zero stand-in divisor keeps the dividers defined when B is zero.
  assign dvs  = div_by_zero ? 32'd1 : B;
  assign sovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    sq = '0;
    sr = '0;
    if (sovf) begin
      sq = 32'h8000_0000;
      sr = '0;
    end else begin
      sq = $signed(A) / $signed(dvs);
      sr = $signed(A) % $signed(dvs);
    end
  end

  assign uq = A / dvs;
  assign ur = A % dvs;

  always_comb begin
    nHI = HI;
    nLO = LO;
    case (MDop)
      MD_MULT:  {nHI, nLO} = sprod;
      MD_MULTU: {nHI, nLO} = uprod;
      MD_MADD:  {nHI, nLO} = acc + sprod;
      MD_MSUB:  {nHI, nLO} = acc - sprod;
      MD_DIV: begin
        nHI = sr;
        nLO = sq;
      end
      MD_DIVU: begin
        nHI = ur;
        nLO = uq;
      end
      default: begin
        nHI = HI;
        nLO = LO;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: latches the result at start, holds Busy for a fixed
// latency, then commits to the architectural HI/LO. Also services mthi/mtlo.
module mult_div_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIwrite,
  input  logic        LOwrite,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] pHI;
  logic [31:0] pLO;
  logic        pdz;
  logic [31:0] nHI;
  logic [31:0] nLO;
  logic        dz;
  logic [3:0]  n_load;

  md_arith u_arith (
    .A           (A),
    .B           (B),
    .MDop        (MDop),
    .HI          (HI),
    .LO          (LO),
    .nHI         (nHI),
    .nLO         (nLO),
    .div_by_zero (dz)
  );

  assign n_load = md_is_div(MDop) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  assign Busy   = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pHI   <= '0;
      pLO   <= '0;
      pdz   <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && md_valid(MDop)) begin
            pHI   <= nHI;
            pLO   <= nLO;
            pdz   <= md_is_div(MDop) && dz;
            cnt   <= n_load;
            state <= RUN;
          end else begin
            if (HIwrite) HI <= A;
            if (LOwrite) LO <= A;
          end
        end
        RUN: begin
          // Everything on the request side is ignored until the commit edge.
          if (cnt == 4'd1) begin
            if (!pdz) begin
              HI <= pHI;
              LO <= pLO;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- HI/LO multiply-divide responder driven by the execute stage.
- Accepts a one-cycle start pulse with an opcode and two 32-bit operands.
- Holds Busy for a fixed latency, then commits the result to the architectural HI/LO registers.
- Also services direct HI/LO writes (mthi/mtlo); HI and LO are read combinationally for mfhi/mflo forwarding into the execute-stage write-data mux.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu/madd/msub (range 1..15)
DIV_CYCLES, 10, Busy cycles for div/divu (range 1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle request pulse; operation selected by MDop
MDop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 msub, 11x reserved
A  input  32  operand rs (forwarded value)
B  input  32  operand rt (forwarded value)
HIwrite  input  1  mthi: HI <= A
LOwrite  input  1  mtlo: LO <= A
Busy  output  1  operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0; any pending result is discarded. Reset mid-operation aborts the operation; no commit follows on release.
- States: IDLE, RUN.
- IDLE, start=1 with a valid MDop at edge T:
  - Latch the computed result into internal pending registers pHI/pLO.
  - Load the counter with N (MULT_CYCLES or DIV_CYCLES).
  - Go to RUN; Busy=1 from the cycle after T.
- RUN: counter decrements each edge. On the edge where the counter reaches 1: HI<=pHI, LO<=pLO, Busy<=0, state<=IDLE.
  - Busy is high for exactly N cycles.
  - New HI/LO are visible in the first cycle Busy is low.
- HI/LO never change during RUN; intermediate values are never exposed.
- start, HIwrite, LOwrite while Busy=1: ignored. The hazard unit must stall these instructions; the unit must still not corrupt state.
- start with reserved MDop (11x): ignored, Busy stays 0.
- start and HIwrite/LOwrite both asserted in IDLE: start wins; the write is ignored.
- HIwrite and LOwrite both asserted: HI<=A and LO<=A on the same edge. Writes take effect at the next edge with no Busy.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit A*B.
  - multu: unsigned 64-bit product.
  - madd: {HI,LO} += signed A*B, using the HI/LO values at the start edge, mod 2^64.
  - msub: {HI,LO} -= signed A*B.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu): the operation still runs DIV_CYCLES with Busy; HI and LO are left unchanged at commit.
- Back-to-back: start is accepted in the first cycle Busy=0 after a commit. Operands may read the freshly committed HI/LO (madd chain).

Decomposition:
- Shared package md_defs: MDop encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MSUB), state encodings IDLE/RUN, default cycle constants. The Controller decode uses the same constants.
- One sub-module, md_arith: purely combinational. Inputs A, B, MDop, HI, LO. Outputs nHI, nLO, div_by_zero.
- mult_div_unit owns the FSM, counter, pending registers and architectural HI/LO.

Test Plan:
- Reset: hold reset=0, then release -> HI=0, LO=0, Busy=0. Assert reset=0 asynchronously during a div -> Busy drops immediately, HI/LO=0, no later commit.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 after HI=0x11, LO=0x22 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- mthi A=0x12345678, then mtlo A=0x9 -> HI=0x12345678, LO=0x9 on the next cycle. Then madd A=2, B=3 -> after 5 cycles HI=0x12345678, LO=0xF.
- During a mult Busy window, pulse start with div and HIwrite with A=0xDEAD -> both ignored; the mult result is committed unchanged. Then start immediately in the first non-busy cycle -> accepted.
- start=1 with HIwrite=1 in IDLE: mult A=4, B=5 -> HI=0, LO=20; the HIwrite is ignored. start with MDop=110 -> Busy stays 0, HI/LO unchanged.
